// File: rtl/imem_pkg.sv
// Shared definitions for the instruction fetch path: default widths and fetch FSM encoding.
package imem_pkg;
    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 32;
    localparam int DEPTH_DEF    = 2;
    localparam int RESET_PC_DEF = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding {pc, instruction} records; head is visible without a read cycle.
module fetch_queue #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_q];
    assign count     = cnt_q;
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives the async instruction memory and
// buffers fetched words in a prefetch queue handed to the consumer by valid/ready.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic [DATA_W-1:0]        imem_addr,
    input  logic [DATA_W-1:0]        imem_data,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [DATA_W-1:0]        inst_data,
    output logic [ADDR_W-1:0]        inst_pc,
    output logic [$clog2(DEPTH):0]   q_count
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e             state_q, state_d;
    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_next;
    logic [ADDR_W+DATA_W-1:0] head;
    logic                     nonempty;
    logic                     pop;
    logic                     push;

    assign nonempty   = (cnt != '0);
    assign inst_valid = nonempty & ~redirect;
    assign pop        = inst_valid & inst_ready;
    // Only FETCH pushes; FULL waits one cycle after a pop so imem_addr never depends on inst_ready.
    assign push       = (state_q == ST_FETCH) & ~redirect & ((cnt < DEPTH_C) | pop);
    assign cnt_next   = redirect ? '0 : (cnt + CNT_W'(push) - CNT_W'(pop));

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            state_d = fetch_en ? ST_FETCH : ST_IDLE;
        end else begin
            if (push) begin
                pc_d = pc_q + 1'b1;
            end
            case (state_q)
                ST_IDLE:  if (fetch_en) state_d = ST_FETCH;
                ST_FETCH: begin
                    if (!fetch_en)               state_d = ST_IDLE;
                    else if (cnt_next == DEPTH_C) state_d = ST_FULL;
                end
                ST_FULL: begin
                    if (!fetch_en)              state_d = ST_IDLE;
                    else if (cnt_next < DEPTH_C) state_d = ST_FETCH;
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= ADDR_W'(RESET_PC);
            state_q <= ST_IDLE;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    fetch_queue #(
        .WIDTH(ADDR_W + DATA_W),
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push),
        .push_data ({pc_q, imem_data}),
        .pop       (pop),
        .head_data (head),
        .count     (cnt)
    );

    assign imem_addr = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
    assign inst_data = nonempty ? head[DATA_W-1:0] : '0;
    assign inst_pc   = nonempty ? head[ADDR_W+DATA_W-1:DATA_W] : '0;
    assign q_count   = cnt;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed vector table, hand sequences for redirect/wrap/reset,
// then random traffic checked against a queue-based reference model.
module tb_imem_fetch_ctrl;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DP = 2;
    localparam int MODEL_IDLE  = 0;
    localparam int MODEL_RUN   = 1;
    localparam int MODEL_STALL = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_en = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [DW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_pc;
    logic [1:0]    q_count;

    logic [DW-1:0] mem [32];
    assign imem_data = mem[imem_addr[AW-1:0]];

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .q_count(q_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: the queue contents as a list of {pc, word} and a fetch pointer.
    typedef struct { int pc; logic [31:0] data; } ent_t;
    ent_t mq[$];
    int   m_pc   = 0;
    int   m_mode = MODEL_IDLE;
    bit   m_live = 1'b0;

    task automatic model_check(input string tag);
        logic [31:0] e_data;
        int          e_pc;
        e_data = (mq.size() != 0) ? mq[0].data : 32'h0;
        e_pc   = (mq.size() != 0) ? mq[0].pc : 0;
        check({tag, ".valid"}, 32'(inst_valid), 32'((mq.size() != 0) && !redirect));
        check({tag, ".count"}, 32'(q_count), 32'(mq.size()));
        check({tag, ".addr"},  imem_addr, 32'(m_pc));
        check({tag, ".data"},  inst_data, e_data);
        check({tag, ".pc"},    32'(inst_pc), 32'(e_pc));
    endtask

    task automatic model_update();
        bit   pop, push;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_pc   = 0;
            m_mode = MODEL_IDLE;
            m_live = 1'b1;
        end else if (redirect) begin
            mq.delete();
            m_pc   = int'(redirect_pc);
            m_mode = fetch_en ? MODEL_RUN : MODEL_IDLE;
        end else begin
            pop  = (mq.size() != 0) && inst_ready;
            push = (m_mode == MODEL_RUN) && ((mq.size() < DP) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.pc   = m_pc;
                e.data = mem[m_pc];
                mq.push_back(e);
                m_pc = (m_pc + 1) % 32;
            end
            if (!fetch_en)                                   m_mode = MODEL_IDLE;
            else if (m_mode == MODEL_IDLE)                   m_mode = MODEL_RUN;
            else if (m_mode == MODEL_RUN && mq.size() == DP) m_mode = MODEL_STALL;
            else if (m_mode == MODEL_STALL && mq.size() < DP) m_mode = MODEL_RUN;
        end
    endtask

    task automatic apply(input bit r, input bit e, input bit y, input bit rd, input int rpc, input string tag);
        rst_n       = r;
        fetch_en    = e;
        inst_ready  = y;
        redirect    = rd;
        redirect_pc = AW'(rpc);
        @(negedge clk);
        if (m_live) model_check(tag);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct { bit r; bit e; bit y; bit chk; int vld; int pc; int cnt; int addr; } vec_t;
    vec_t tbl[18];

    task automatic row(input int i, input bit r, input bit e, input bit y, input bit c,
                       input int v, input int p, input int n, input int a);
        tbl[i].r = r; tbl[i].e = e; tbl[i].y = y; tbl[i].chk = c;
        tbl[i].vld = v; tbl[i].pc = p; tbl[i].cnt = n; tbl[i].addr = a;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);

        //        r  e  y  chk v  pc cnt addr
        row(0,  0, 1, 1, 0,  0, 0, 0, 0);
        row(1,  1, 1, 1, 1,  0, 0, 0, 0);
        row(2,  1, 1, 1, 1,  0, 0, 0, 0);
        row(3,  1, 1, 1, 1,  1, 0, 1, 1);
        row(4,  1, 1, 1, 1,  1, 1, 1, 2);
        row(5,  1, 1, 1, 1,  1, 2, 1, 3);
        row(6,  0, 1, 0, 1,  1, 3, 1, 4);
        row(7,  1, 1, 0, 1,  0, 0, 0, 0);
        row(8,  1, 1, 0, 1,  0, 0, 0, 0);
        row(9,  1, 1, 0, 1,  1, 0, 1, 1);
        row(10, 1, 1, 0, 1,  1, 0, 2, 2);
        row(11, 1, 1, 0, 1,  1, 0, 2, 2);
        row(12, 1, 1, 0, 1,  1, 0, 2, 2);
        row(13, 1, 1, 1, 1,  1, 0, 2, 2);
        row(14, 1, 1, 0, 1,  1, 1, 1, 2);
        row(15, 1, 1, 1, 1,  1, 1, 2, 3);
        row(16, 1, 1, 1, 1,  1, 2, 1, 3);
        row(17, 1, 1, 0, 1,  1, 3, 1, 4);

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i].r, tbl[i].e, tbl[i].y, 1'b0, 0, $sformatf("row%0d", i));
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d.valid", i), 32'(inst_valid), 32'(tbl[i].vld));
                check($sformatf("tbl%0d.count", i), 32'(q_count), 32'(tbl[i].cnt));
                check($sformatf("tbl%0d.addr", i), imem_addr, 32'(tbl[i].addr));
                check($sformatf("tbl%0d.pc", i), 32'(inst_pc), 32'(tbl[i].cnt != 0 ? tbl[i].pc : 0));
                check($sformatf("tbl%0d.data", i), inst_data,
                      tbl[i].cnt != 0 ? 32'h1000_0000 + 32'(tbl[i].pc) : 32'h0);
            end
            $display("vec %0d: valid=%0d pc=%0d count=%0d addr=%0h", i, inst_valid, inst_pc, q_count, imem_addr);
            advance();
        end

        // Redirect to 7 while the queue holds pc 3,4.
        apply(1, 1, 1, 1, 7, "redir");
        check("redir.no_transfer", 32'(inst_valid), 32'h0);
        check("redir.count_before", 32'(q_count), 32'd2);
        advance();
        apply(1, 1, 1, 0, 0, "redir1");
        check("redir1.count", 32'(q_count), 32'd0);
        check("redir1.addr", imem_addr, 32'd7);
        advance();
        apply(1, 1, 1, 0, 0, "redir2");
        check("redir2.pc", 32'(inst_pc), 32'd7);
        check("redir2.data", inst_data, 32'h1000_0007);
        advance();

        // PC wrap from 31 to 0.
        apply(1, 1, 1, 1, 30, "wrap0");
        advance();
        apply(1, 1, 1, 0, 0, "wrap1");
        check("wrap1.addr", imem_addr, 32'h1E);
        advance();
        apply(1, 1, 1, 0, 0, "wrap2");
        check("wrap2.pc", 32'(inst_pc), 32'd30);
        check("wrap2.addr", imem_addr, 32'h1F);
        advance();
        apply(1, 1, 1, 0, 0, "wrap3");
        check("wrap3.pc", 32'(inst_pc), 32'd31);
        check("wrap3.addr", imem_addr, 32'h00);
        advance();
        apply(1, 1, 1, 0, 0, "wrap4");
        check("wrap4.pc", 32'(inst_pc), 32'd0);
        advance();

        // Reset mid-stream.
        apply(0, 1, 1, 0, 0, "mrst0");
        advance();
        apply(1, 1, 1, 0, 0, "mrst1");
        check("mrst1.valid", 32'(inst_valid), 32'h0);
        check("mrst1.count", 32'(q_count), 32'd0);
        check("mrst1.addr", imem_addr, 32'd0);
        advance();
        advance();
        apply(1, 1, 1, 0, 0, "mrst3");
        check("mrst3.pc", 32'(inst_pc), 32'd0);
        check("mrst3.data", inst_data, 32'h1000_0000);
        advance();

        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 99) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0, int'($urandom_range(0, 31)), $sformatf("rnd%0d", i));
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
